// File: rtl/parallel_to_serial.sv
// Splits one N-bit word into bytes (MSB first) for a UART transmitter, pacing on tx_busy.
// First strobe one edge after acceptance, then one byte per 3 edges when tx_busy stays low; in_ready only in IDLE.
module parallel_to_serial #(
  parameter int N = 16
) (
  input  logic         iCE_CLK,
  input  logic         rst,
  input  logic [N-1:0] in_word,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [7:0]   tx_byte,
  output logic         tx_valid,
  input  logic         tx_busy,
  output logic         done
);

  localparam int NBYTES = N / 8;
  localparam int CW     = $clog2(NBYTES + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_GUARD,
    S_WAIT
  } state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  shreg_q, shreg_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    tx_byte_q, tx_byte_d;
  logic          tx_valid_q, tx_valid_d;
  logic          done_q, done_d;

  always_ff @(posedge iCE_CLK or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      shreg_q    <= '0;
      count_q    <= '0;
      tx_byte_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      count_q    <= count_d;
      tx_byte_q  <= tx_byte_d;
      tx_valid_q <= tx_valid_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    count_d    = count_q;
    tx_byte_d  = tx_byte_q;
    tx_valid_d = 1'b0;
    done_d     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          shreg_d = in_word;
          count_d = '0;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        if (!tx_busy) begin
          tx_byte_d  = shreg_q[N-1 -: 8];
          tx_valid_d = 1'b1;
          shreg_d    = shreg_q << 8;
          count_d    = count_q + 1'b1;
          state_d    = S_GUARD;
        end
      end
      // Transmitter may raise busy one cycle late, so busy is not trusted here.
      S_GUARD: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (!tx_busy) begin
          if (count_q == CW'(NBYTES)) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_SEND;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign in_ready = (state_q == S_IDLE);
  assign tx_byte  = tx_byte_q;
  assign tx_valid = tx_valid_q;
  assign done     = done_q;

endmodule

// File: doc/parallel_to_serial.md
Name: parallel_to_serial

Overview:
Transmit-side word splitter for the UART path. It accepts one N-bit word from the core through a valid/ready handshake. It then feeds the word to the UART transmitter one byte at a time, most-significant byte first, pacing on the transmitter's busy flag. It pulses done once the last byte has been handed off.

Parameters:
- N, 16, word width in bits; must be a multiple of 8 and at least 8.
- NBYTES = N/8, localparam, bytes per word; the internal byte counter is sized to hold 0..NBYTES.

Ports:
- iCE_CLK  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_word  input  N  word to transmit; sampled only on acceptance.
- in_valid  input  1  core offers in_word.
- in_ready  output  1  block can accept a word; high only in IDLE.
- tx_byte  output  8  byte presented to the UART transmitter.
- tx_valid  output  1  one-cycle strobe; tx_byte is valid while it is high.
- tx_busy  input  1  UART transmitter is shifting a byte out (level).
- done  output  1  one-cycle pulse when the final byte of a word has been accepted by the UART.

Behaviour:
- Reset (async, immediate):
  - state=IDLE, shift register=0, count=0, tx_byte=8'h00, tx_valid=0, done=0.
  - in_ready=1 once rst deasserts.
- All outputs are registered except in_ready, which is decoded directly from state==IDLE.
- States: IDLE, SEND, GUARD, WAIT.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1: load shreg<=in_word, count<=0, go to SEND.
  - Otherwise stay in IDLE.
- SEND:
  - On an edge with tx_busy=0: tx_byte<=shreg[N-1:N-8], tx_valid<=1, shreg<=shreg<<8 (zero fill), count<=count+1, go to GUARD.
  - On an edge with tx_busy=1: stay in SEND, no strobe.
- GUARD:
  - Lasts exactly one cycle; tx_busy is ignored.
  - tx_valid<=0, go to WAIT.
  - This covers a transmitter that raises busy one cycle after the strobe.
- WAIT:
  - On an edge with tx_busy=0: if count==NBYTES, done<=1 and go to IDLE; otherwise go to SEND.
  - On an edge with tx_busy=1: stay in WAIT.
- done is high for exactly one cycle, coinciding with the first cycle back in IDLE.
  - in_ready is also high in that cycle, so a new word can be accepted there.
- Latency with tx_busy always 0:
  - Acceptance edge E0; tx_valid high in the cycle after E1.
  - Byte k strobes at edge E(1+3k).
  - done is high in the cycle after edge E(3*NBYTES).
- tx_byte holds its last value while tx_valid=0; it is not cleared between bytes.
- in_valid and in_word are ignored outside IDLE; there is no queuing, and the core must re-present the word.
- tx_busy stuck high: the block waits indefinitely in SEND or WAIT; there is no timeout.
- Reset mid-word: the transfer is aborted, remaining bytes are dropped, and no done pulse is issued. A tx_valid that is high is cleared immediately.
- N=8: a single byte is sent, and done follows the first WAIT exit.

Test Plan:
- Case 1: N=16, in_word=16'hA55A, in_valid held one cycle; UART model asserts busy 1 cycle after each strobe for 10 cycles.
  -> Exactly two tx_valid strobes, tx_byte=8'hA5 then 8'h5A, done pulses once after the second busy drop, in_ready low throughout.
- Case 2: N=32, in_word=32'hDEADBEEF, tx_busy tied 0.
  -> Strobes every 3 cycles carrying DE, AD, BE, EF; done high 12 cycles after acceptance; tx_valid never high two consecutive cycles.
- Case 3: tx_busy held high for 20 cycles before a word 16'h1234 is accepted.
  -> No tx_valid until the first edge with tx_busy=0, then 12 and 34 sent normally.
- Case 4: back-to-back words 16'h0102 and 16'h0304, with the second in_valid asserted during the done cycle.
  -> Second word accepted on that edge; byte stream 01,02,03,04; two done pulses.
- Case 5: in_valid pulsed with 16'hFFFF while the block is mid-word on 16'h0A0B.
  -> Ignored; only 0A,0B emitted.
- Case 6: rst asserted asynchronously between byte 1 and byte 2 of 16'hC3D4.
  -> tx_valid/done/tx_byte go to 0 immediately, in_ready=1 after release, byte D4 never emitted, next word transmits correctly.
